// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared types and constants for the calculator input path.
//   bcd_digit_t  : one packed BCD digit
//   BCD_CORR     : amount taken off a digit after a right shift (reverse double-dabble)
//   BCD_THRESH   : a digit at or above this value needs the correction
//   BCD_MAX      : largest legal BCD digit value
//   conv_state_t : converter FSM states
// -----------------------------------------------------------------------------
package calc_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_CORR   = 4'd3;
  localparam bcd_digit_t BCD_THRESH = 4'd8;
  localparam bcd_digit_t BCD_MAX    = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } conv_state_t;

endpackage

// File: rtl/bcd2binary_seq_if.sv
// -----------------------------------------------------------------------------
// bcd2binary_seq_if
// Operand-in / result-out bundle of the BCD-to-binary converter.
//
// Handshake (both directions): a transfer happens on a rising clock edge where
// valid and ready are both 1. The producer holds valid and its data stable
// until that edge; ready may change freely and never depends on valid.
//
//   in_valid/in_ready/bcd_in          : operand from keypad/entry logic
//   out_valid/out_ready/bin_out/flags : result to the ALU operand registers
//   master modport : operand producer + result consumer
//   slave modport  : the converter
// -----------------------------------------------------------------------------
interface bcd2binary_seq_if #(
  parameter int NDIGITS = 5,
  parameter int BIN_W   = 16
);

  logic                   in_valid;
  logic                   in_ready;
  logic [4*NDIGITS-1:0]   bcd_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [BIN_W-1:0]       bin_out;
  logic                   err_digit;
  logic                   overflow;

  modport master (
    output in_valid, bcd_in, out_ready,
    input  in_ready, out_valid, bin_out, err_digit, overflow
  );

  modport slave (
    input  in_valid, bcd_in, out_ready,
    output in_ready, out_valid, bin_out, err_digit, overflow
  );

endinterface

// File: rtl/bcd_sub3.sv
// -----------------------------------------------------------------------------
// bcd_sub3
// Per-digit correction step of reverse double-dabble: after the right shift a
// digit that reads 8 or more has picked up a 16/2 = 8 that should be 10/2 = 5,
// so 3 is taken off.
//   in_i  : digit after the shift
//   out_o : corrected digit
// -----------------------------------------------------------------------------
module bcd_sub3
  import calc_pkg::*;
(
  input  bcd_digit_t in_i,
  output bcd_digit_t out_o
);

  assign out_o = (in_i >= BCD_THRESH) ? bcd_digit_t'(in_i - BCD_CORR) : in_i;

endmodule

// File: rtl/bcd2binary_seq.sv
// -----------------------------------------------------------------------------
// bcd2binary_seq
// Sequential BCD-to-binary converter. An accepted operand is shifted right one
// bit per cycle through a {BCD field, binary field} register for BIN_W cycles;
// after each shift every BCD digit is corrected in parallel. Whatever value is
// left in the BCD field after the last shift is the part of the number that
// did not fit in BIN_W bits, so it doubles as the overflow indicator.
// Operands with an illegal digit skip conversion and report err_digit.
//
// Ports
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   bus     : slave side of bcd2binary_seq_if (operand in, result out)
//   state_o : current FSM state, for observation
// -----------------------------------------------------------------------------
module bcd2binary_seq
  import calc_pkg::*;
#(
  parameter int NDIGITS = 5,
  parameter int BIN_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bcd2binary_seq_if.slave      bus,
  output conv_state_t          state_o
);

  localparam int BCD_W = 4 * NDIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  conv_state_t       state_q, state_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [SR_W-1:0]   sr_shr;
  logic [SR_W-1:0]   sr_step;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;
  logic              bad_digit;

  // One conversion step: shift, then correct every BCD digit.
  assign sr_shr = sr_q >> 1;
  assign sr_step[BIN_W-1:0] = sr_shr[BIN_W-1:0];

  for (genvar g = 0; g < NDIGITS; g++) begin : g_digit
    bcd_sub3 u_sub3 (
      .in_i  (sr_shr[BIN_W+4*g +: 4]),
      .out_o (sr_step[BIN_W+4*g +: 4])
    );
  end

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (bus.bcd_in[4*i +: 4] > BCD_MAX) bad_digit = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (bad_digit) begin
            bin_d   = '0;
            err_d   = 1'b1;
            ovf_d   = 1'b0;
            state_d = DONE;
          end else begin
            sr_d    = {bus.bcd_in, {BIN_W{1'b0}}};
            cnt_d   = '0;
            state_d = CONV;
          end
        end
      end
      CONV: begin
        sr_d  = sr_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // Latch from the step being taken this cycle, not from sr_q.
          bin_d   = sr_step[BIN_W-1:0];
          ovf_d   = |sr_step[SR_W-1:BIN_W];
          err_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.bin_out   = bin_q;
  assign bus.err_digit = err_q;
  assign bus.overflow  = ovf_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_bcd2binary_seq.sv
module tb_bcd2binary_seq;
  import calc_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  bcd2binary_seq_if #(.NDIGITS(5), .BIN_W(16)) bus ();
  conv_state_t state;

  bcd2binary_seq #(.NDIGITS(5), .BIN_W(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc++;

  // Scoreboard entry: {err_digit, overflow, bin_out}
  logic [17:0] exp_q[$];
  bit model_busy = 1'b0;
  bit rand_phase = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Decimal meaning of the operand, reduced to the output fields.
  function automatic logic [17:0] model(input logic [19:0] b);
    int v;
    bit bad;
    logic [3:0] d;
    v = 0;
    bad = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      d = b[4*i +: 4];
      if (d > 4'd9) bad = 1'b1;
      v = v * 10 + int'(d);
    end
    if (bad) return {1'b1, 1'b0, 16'h0000};
    return {1'b0, (v >= 65536), v[15:0]};
  endfunction

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] b;
    int x;
    x = v;
    b = '0;
    for (int i = 0; i < 5; i++) begin
      b[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return b;
  endfunction

  // ---------------- compare process ----------------
  initial begin
    int acc_cyc;
    int lat;
    bit exp_valid;
    logic [17:0] e;
    acc_cyc = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        exp_q.delete();
        model_busy = 1'b0;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_bin_out",   32'(bus.bin_out), 0);
        chk("rst_err_digit", 32'(bus.err_digit), 0);
        chk("rst_overflow",  32'(bus.overflow), 0);
        chk("rst_state",     32'(state), 32'(IDLE));
      end else begin
        chk("in_ready", 32'(bus.in_ready), 32'(!model_busy));
        exp_valid = 1'b0;
        e = '0;
        if (model_busy) begin
          e = exp_q[0];
          lat = e[17] ? 0 : 16;
          exp_valid = ((cyc - acc_cyc) >= lat);
        end
        chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
        if (bus.out_valid && exp_valid) begin
          chk("bin_out",   32'(bus.bin_out), 32'(e[15:0]));
          chk("err_digit", 32'(bus.err_digit), 32'(e[17]));
          chk("overflow",  32'(bus.overflow), 32'(e[16]));
        end
        if (model_busy && bus.out_valid && bus.out_ready) begin
          void'(exp_q.pop_front());
          model_busy = 1'b0;
        end else if (!model_busy && bus.in_valid && bus.in_ready) begin
          exp_q.push_back(model(bus.bcd_in));
          model_busy = 1'b1;
          acc_cyc = cyc + 1;
        end
      end
    end
  end

  // Random backpressure during the random phase.
  initial begin
    forever begin
      @(negedge clk);
      if (rand_phase) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [19:0] v);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.bcd_in   = v;
    #1;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("send_timeout", 32'(n < 200), 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [15:0] b, input bit e, input bit o);
    int n;
    n = 0;
    #1;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({name, "_timeout"}, 32'(n < 100), 1);
    chk({name, "_bin"}, 32'(bus.bin_out), 32'(b));
    chk({name, "_err"}, 32'(bus.err_digit), 32'(e));
    chk({name, "_ovf"}, 32'(bus.overflow), 32'(o));
    chk({name, "_state"}, 32'(state), 32'(DONE));
    @(negedge clk);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n;
    int v;
    bus.in_valid  = 1'b0;
    bus.bcd_in    = '0;
    bus.out_ready = 1'b1;

    // Pin the model against hand-computed values.
    chk("model_12345", 32'(model(20'h12345)), 32'(18'h03039));
    chk("model_65536", 32'(model(20'h65536)), 32'(18'h10000));
    chk("model_00A00", 32'(model(20'h00A00)), 32'(18'h20000));
    chk("model_99999", 32'(model(20'h99999)), 32'(18'h1869F));

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", 32'(bus.in_ready), 1);
    chk("reset_out_valid", 32'(bus.out_valid), 0);

    send(20'h12345);  expect_out("t1_12345", 16'h3039, 1'b0, 1'b0);
    send(20'h65535);  expect_out("t2_65535", 16'hFFFF, 1'b0, 1'b0);
    send(20'h65536);  expect_out("t2_65536", 16'h0000, 1'b0, 1'b1);
    send(20'h00A00);  expect_out("t3_00A00", 16'h0000, 1'b1, 1'b0);
    send(20'h00000);  expect_out("t_zero",   16'h0000, 1'b0, 1'b0);
    send(20'h99999);  expect_out("t_99999",  16'h869F, 1'b0, 1'b1);
    send(20'hF0000);  expect_out("t_F0000",  16'h0000, 1'b1, 1'b0);

    // Backpressure: result held, second operand waits for the hand-off.
    bus.out_ready = 1'b0;
    send(20'h00042);
    expect_out("t4_00042", 16'h002A, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    bus.bcd_in   = 20'h00777;
    repeat (10) begin
      @(negedge clk);
      #1;
      chk("t4_hold_bin", 32'(bus.bin_out), 32'h002A);
      chk("t4_hold_valid", 32'(bus.out_valid), 1);
      chk("t4_in_ready", 32'(bus.in_ready), 0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    send(20'h00777);
    expect_out("t4_00777", 16'h0309, 1'b0, 1'b0);

    // Reset in the middle of a conversion.
    send(20'h12345);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(bus.out_valid), 0);
    chk("t5_rst_bin", 32'(bus.bin_out), 0);
    chk("t5_rst_state", 32'(state), 32'(IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t5_in_ready", 32'(bus.in_ready), 1);
    send(20'h00099);
    expect_out("t5_00099", 16'h0063, 1'b0, 1'b0);

    // Random legal operands with random backpressure; the compare process checks them.
    rand_phase = 1'b1;
    for (int i = 0; i < 24; i++) begin
      v = int'($urandom_range(0, 99999));
      send(to_bcd(v));
    end
    n = 0;
    while (model_busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("t6_drain", 32'(model_busy), 0);
    #2;
    rand_phase = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
